// File: rtl/keccak_cmd_issuer_pkg.sv
// Shared constants, command layouts and FSM state types for the adapted-Keccak
// command issuer and its absorb-stream sequencer.
package keccak_cmd_issuer_pkg;

    localparam int KECCAK_BLK_CNT_W  = 9;
    localparam int KECCAK_IN_CMD_W   = 11;
    localparam int KECCAK_OUT_CMD_W  = 2;

    // Core command layout, LSB first: secondaryNumBlocks, numBlocks,
    // mainIsInElseOut, outState, inState, is128else256.
    localparam int ADP_SEC_LSB       = 0;
    localparam int ADP_MAIN_LSB      = KECCAK_BLK_CNT_W;
    localparam int ADP_MAIN_IS_IN    = 2 * KECCAK_BLK_CNT_W;
    localparam int ADP_OUT_STATE     = 2 * KECCAK_BLK_CNT_W + 1;
    localparam int ADP_IN_STATE      = 2 * KECCAK_BLK_CNT_W + 2;
    localparam int ADP_IS128         = 2 * KECCAK_BLK_CNT_W + 3;
    localparam int KECCAK_ADAPTED_CMD_W = 2 * KECCAK_BLK_CNT_W + 4;

    typedef enum logic [1:0] {
        IN_OP_BYTE  = 2'b00,
        IN_OP_ZEROS = 2'b01,
        IN_OP_FWD   = 2'b10
    } in_op_e;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_RUN  = 1'b1
    } iss_state_e;

    typedef enum logic [1:0] {
        IN_BYTE  = 2'b00,
        IN_ZEROS = 2'b01,
        IN_FWD   = 2'b10,
        IN_FIN   = 2'b11
    } in_state_e;

    function automatic logic [KECCAK_IN_CMD_W-1:0] pack_in_cmd(
        input logic [7:0] byte_val,
        input logic       skip_is_last,
        input in_op_e     op
    );
        return {byte_val, skip_is_last, op};
    endfunction

endpackage

// File: rtl/keccak_cmd_issuer_in_seq.sv
// Absorb-stream sequencer: walks byte -> zeros -> forward, skipping disabled
// entries, and marks every entry but the last with skipIsLast.
module keccak_cmd_issuer_in_seq
    import keccak_cmd_issuer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_has_domain,
    input  logic [7:0]                 i_domain_byte,
    input  logic [7:0]                 i_zeros,
    input  logic                       i_forward,
    output logic [KECCAK_IN_CMD_W-1:0] o_cmd,
    output logic                       o_is_ready,
    input  logic                       i_can_receive,
    output logic                       o_fin
);

    in_state_e  r_state;
    in_state_e  w_state_nxt;
    logic [7:0] r_domain_byte;
    logic [7:0] r_zeros;
    logic       r_forward;
    logic       w_xfer;

    assign w_xfer     = (r_state != IN_FIN) && i_can_receive;
    assign o_is_ready = (r_state != IN_FIN);
    // Finished now, or finishing on this edge, so the top can retire the job
    // in the same edge as the last transfer.
    assign o_fin      = (r_state == IN_FIN) || (w_xfer && (w_state_nxt == IN_FIN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IN_FIN;
            r_domain_byte <= 8'h00;
            r_zeros       <= 8'h00;
            r_forward     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_start && (r_state == IN_FIN)) begin
                r_domain_byte <= i_domain_byte;
                r_zeros       <= i_zeros;
                r_forward     <= i_forward;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cmd       = '0;
        case (r_state)
            IN_FIN: begin
                if (i_start) begin
                    if (i_has_domain)
                        w_state_nxt = IN_BYTE;
                    else if (i_zeros != 8'h00)
                        w_state_nxt = IN_ZEROS;
                    else if (i_forward)
                        w_state_nxt = IN_FWD;
                    else
                        w_state_nxt = IN_FIN;
                end
            end
            IN_BYTE: begin
                o_cmd = pack_in_cmd(r_domain_byte, (r_zeros != 8'h00) || r_forward, IN_OP_BYTE);
                if (w_xfer) begin
                    if (r_zeros != 8'h00)
                        w_state_nxt = IN_ZEROS;
                    else if (r_forward)
                        w_state_nxt = IN_FWD;
                    else
                        w_state_nxt = IN_FIN;
                end
            end
            IN_ZEROS: begin
                o_cmd = pack_in_cmd(r_zeros, r_forward, IN_OP_ZEROS);
                if (w_xfer)
                    w_state_nxt = r_forward ? IN_FWD : IN_FIN;
            end
            IN_FWD: begin
                o_cmd = pack_in_cmd(8'h00, 1'b0, IN_OP_FWD);
                if (w_xfer)
                    w_state_nxt = IN_FIN;
            end
            default: begin
                w_state_nxt = IN_FIN;
            end
        endcase
    end

endmodule

// File: rtl/keccak_cmd_issuer.sv
// Expands one FrodoKEM hashing job into the core, absorb and squeeze command
// streams of adapted_keccak; the three streams drain independently.
module keccak_cmd_issuer
    import keccak_cmd_issuer_pkg::*;
#(
    parameter int BLK_W    = KECCAK_BLK_CNT_W,
    parameter int OUTCNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_isReady,
    output logic                       job_canReceive,
    input  logic                       job_is128else256,
    input  logic                       job_hasDomain,
    input  logic [7:0]                 job_domainByte,
    input  logic [7:0]                 job_zeros,
    input  logic                       job_forward,
    input  logic [BLK_W-1:0]           job_numBlocks,
    input  logic [OUTCNT_W-1:0]        job_numOutCmds,
    input  logic                       job_sample,
    output logic [2*BLK_W+3:0]         k__cmd,
    output logic                       k__cmd_isReady,
    input  logic                       k__cmd_canReceive,
    output logic [KECCAK_IN_CMD_W-1:0] k_in__cmd,
    output logic                       k_in__cmd_isReady,
    input  logic                       k_in__cmd_canReceive,
    output logic [KECCAK_OUT_CMD_W-1:0] k_out__cmd,
    output logic                       k_out__cmd_isReady,
    input  logic                       k_out__cmd_canReceive,
    output logic                       job_done,
    output logic                       job_err
);

    iss_state_e            r_state;
    iss_state_e            w_state_nxt;
    logic                  r_k_vld;
    logic [2*BLK_W+3:0]    r_k_cmd;
    logic                  r_out_vld;
    logic [OUTCNT_W-1:0]   r_out_cnt;
    logic                  r_sample;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_start;
    logic                  w_k_xfer;
    logic                  w_out_xfer;
    logic                  w_out_last;
    logic                  w_k_fin;
    logic                  w_out_fin;
    logic                  w_in_fin;
    logic                  w_all_fin;

    assign job_canReceive = (r_state == ISS_IDLE);
    assign w_accept       = job_isReady && job_canReceive;
    assign w_legal        = (job_hasDomain || (job_zeros != 8'h00) || job_forward)
                            && (job_numOutCmds != '0);
    assign w_start        = w_accept && w_legal;

    assign w_k_xfer   = r_k_vld && k__cmd_canReceive;
    assign w_out_xfer = r_out_vld && k_out__cmd_canReceive;
    assign w_out_last = (r_out_cnt == OUTCNT_W'(1));
    // Each *_fin is true once the stream has nothing left after this edge.
    assign w_k_fin    = !r_k_vld || w_k_xfer;
    assign w_out_fin  = !r_out_vld || (w_out_xfer && w_out_last);
    assign w_all_fin  = w_k_fin && w_out_fin && w_in_fin;

    assign k__cmd             = r_k_cmd;
    assign k__cmd_isReady     = r_k_vld;
    assign k_out__cmd         = {!w_out_last, r_sample};
    assign k_out__cmd_isReady = r_out_vld;
    assign job_done           = r_done;
    assign job_err            = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ISS_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ISS_RUN) && w_all_fin;
            r_err   <= w_accept && !w_legal;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ISS_IDLE: if (w_start)   w_state_nxt = ISS_RUN;
            ISS_RUN:  if (w_all_fin) w_state_nxt = ISS_IDLE;
            default:                 w_state_nxt = ISS_IDLE;
        endcase
    end

    // Core stream: exactly one command per job, squeeze-only with a single
    // secondary block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k_vld <= 1'b0;
            r_k_cmd <= '0;
        end else if (w_start) begin
            r_k_vld <= 1'b1;
            r_k_cmd <= {job_is128else256, 1'b0, 1'b0, 1'b0, job_numBlocks, BLK_W'(1)};
        end else if (w_k_xfer) begin
            r_k_vld <= 1'b0;
        end
    end

    // Squeeze stream: down-counter from numOutCmds, stops at 1 without wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_vld <= 1'b0;
            r_out_cnt <= '0;
            r_sample  <= 1'b0;
        end else if (w_start) begin
            r_out_vld <= 1'b1;
            r_out_cnt <= job_numOutCmds;
            r_sample  <= job_sample;
        end else if (w_out_xfer) begin
            if (w_out_last)
                r_out_vld <= 1'b0;
            else
                r_out_cnt <= r_out_cnt - OUTCNT_W'(1);
        end
    end

    keccak_cmd_issuer_in_seq u_in_seq (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_start),
        .i_has_domain  (job_hasDomain),
        .i_domain_byte (job_domainByte),
        .i_zeros       (job_zeros),
        .i_forward     (job_forward),
        .o_cmd         (k_in__cmd),
        .o_is_ready    (k_in__cmd_isReady),
        .i_can_receive (k_in__cmd_canReceive),
        .o_fin         (w_in_fin)
    );

endmodule

// File: tb/tb_keccak_cmd_issuer.sv
// Bench for keccak_cmd_issuer: vector table, hand-written corner sequences and
// random jobs with random backpressure against a list-based reference model.
module tb_keccak_cmd_issuer;
    import keccak_cmd_issuer_pkg::*;

    localparam int BLK_W = 9;
    localparam int OUTCNT_W = 4;
    localparam int ADP_W = 2 * BLK_W + 4;
    localparam int IN_W  = 11;
    localparam int OUT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic job_isReady = 1'b0, job_canReceive;
    logic job_is128else256 = 1'b0, job_hasDomain = 1'b0, job_forward = 1'b0, job_sample = 1'b0;
    logic [7:0] job_domainByte = 8'h0, job_zeros = 8'h0;
    logic [BLK_W-1:0] job_numBlocks = '0;
    logic [OUTCNT_W-1:0] job_numOutCmds = '0;
    logic [ADP_W-1:0] k__cmd;
    logic k__cmd_isReady, k__cmd_canReceive = 1'b1;
    logic [IN_W-1:0] k_in__cmd;
    logic k_in__cmd_isReady, k_in__cmd_canReceive = 1'b1;
    logic [OUT_W-1:0] k_out__cmd;
    logic k_out__cmd_isReady, k_out__cmd_canReceive = 1'b1;
    logic job_done, job_err;

    keccak_cmd_issuer #(.BLK_W(BLK_W), .OUTCNT_W(OUTCNT_W)) dut (
        .clk(clk), .rst(rst),
        .job_isReady(job_isReady), .job_canReceive(job_canReceive),
        .job_is128else256(job_is128else256), .job_hasDomain(job_hasDomain),
        .job_domainByte(job_domainByte), .job_zeros(job_zeros), .job_forward(job_forward),
        .job_numBlocks(job_numBlocks), .job_numOutCmds(job_numOutCmds), .job_sample(job_sample),
        .k__cmd(k__cmd), .k__cmd_isReady(k__cmd_isReady), .k__cmd_canReceive(k__cmd_canReceive),
        .k_in__cmd(k_in__cmd), .k_in__cmd_isReady(k_in__cmd_isReady),
        .k_in__cmd_canReceive(k_in__cmd_canReceive),
        .k_out__cmd(k_out__cmd), .k_out__cmd_isReady(k_out__cmd_isReady),
        .k_out__cmd_canReceive(k_out__cmd_canReceive),
        .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is128;
        logic       has_dom;
        logic [7:0] dom;
        logic [7:0] zeros;
        logic       fwd;
        logic [8:0] nblk;
        logic [3:0] nout;
        logic       sample;
    } job_t;

    typedef struct {
        job_t job;
        bit   exp_err;
        int   exp_nin;
        int   exp_nout;
        int   exp_done_cyc;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADP_W-1:0] exp_k[$],  obs_k[$];
    logic [IN_W-1:0]  exp_in[$], obs_in[$];
    logic [OUT_W-1:0] exp_out[$], obs_out[$];
    int g_done_cyc, g_err_cyc, g_last_k, g_last_in, g_last_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: list the enabled absorb entries in order, then mark all but
    // the last with skipIsLast; squeeze entries likewise.
    task automatic build_model(input job_t j, output bit legal);
        logic [7:0] vals[$];
        logic [1:0] ops[$];
        exp_k.delete(); exp_in.delete(); exp_out.delete();
        legal = (j.has_dom || j.zeros != 0 || j.fwd) && (j.nout != 0);
        if (!legal) return;
        exp_k.push_back({j.is128, 3'b000, j.nblk, 9'd1});
        if (j.has_dom)    begin vals.push_back(j.dom);   ops.push_back(2'b00); end
        if (j.zeros != 0) begin vals.push_back(j.zeros); ops.push_back(2'b01); end
        if (j.fwd)        begin vals.push_back(8'h00);   ops.push_back(2'b10); end
        for (int i = 0; i < vals.size(); i++)
            exp_in.push_back({vals[i], (i != vals.size() - 1) ? 1'b1 : 1'b0, ops[i]});
        for (int i = 0; i < int'(j.nout); i++)
            exp_out.push_back({(i != int'(j.nout) - 1) ? 1'b1 : 1'b0, j.sample});
    endtask

    // mode 0: all sinks ready; 1: random sinks; 2: absorb sink stalled 10 cycles.
    // Entered and left at a negedge.
    task automatic run_job(input string nm, input job_t j, input int mode);
        bit legal, stable_bad, any_rdy, can_at_done;
        int done_cnt;
        logic p_rk, p_ri, p_ro, p_xk, p_xi, p_xo;
        logic [ADP_W-1:0] p_ck;
        logic [IN_W-1:0]  p_ci;
        logic [OUT_W-1:0] p_co;
        build_model(j, legal);
        obs_k.delete(); obs_in.delete(); obs_out.delete();
        g_done_cyc = 0; g_err_cyc = 0; g_last_k = 0; g_last_in = 0; g_last_out = 0;
        done_cnt = 0; stable_bad = 0; any_rdy = 0; can_at_done = 0;
        p_rk = 0; p_ri = 0; p_ro = 0; p_xk = 0; p_xi = 0; p_xo = 0;
        p_ck = '0; p_ci = '0; p_co = '0;
        for (int w = 0; w < 50 && !job_canReceive; w++) @(negedge clk);
        job_is128else256 = j.is128; job_hasDomain = j.has_dom; job_domainByte = j.dom;
        job_zeros = j.zeros; job_forward = j.fwd; job_numBlocks = j.nblk;
        job_numOutCmds = j.nout; job_sample = j.sample; job_isReady = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                job_isReady = 1'b0;
                job_hasDomain = 1'($urandom); job_domainByte = 8'($urandom);
                job_zeros = 8'($urandom); job_forward = 1'($urandom);
                job_numBlocks = 9'($urandom); job_numOutCmds = 4'($urandom);
                job_sample = 1'($urandom); job_is128else256 = 1'($urandom);
            end
            case (mode)
                1: begin
                    k__cmd_canReceive = 1'($urandom); k_in__cmd_canReceive = 1'($urandom);
                    k_out__cmd_canReceive = 1'($urandom);
                end
                2: begin
                    k__cmd_canReceive = 1'b1; k_out__cmd_canReceive = 1'b1;
                    k_in__cmd_canReceive = (k > 10);
                end
                default: begin
                    k__cmd_canReceive = 1'b1; k_in__cmd_canReceive = 1'b1;
                    k_out__cmd_canReceive = 1'b1;
                end
            endcase
            if (p_rk && !p_xk && (!k__cmd_isReady || k__cmd !== p_ck)) stable_bad = 1;
            if (p_ri && !p_xi && (!k_in__cmd_isReady || k_in__cmd !== p_ci)) stable_bad = 1;
            if (p_ro && !p_xo && (!k_out__cmd_isReady || k_out__cmd !== p_co)) stable_bad = 1;
            if (k__cmd_isReady || k_in__cmd_isReady || k_out__cmd_isReady) any_rdy = 1;
            if (job_done) begin
                done_cnt++;
                if (g_done_cyc == 0) begin g_done_cyc = k; can_at_done = job_canReceive; end
            end
            if (job_err && g_err_cyc == 0) g_err_cyc = k;
            p_rk = k__cmd_isReady;     p_xk = k__cmd_isReady && k__cmd_canReceive;     p_ck = k__cmd;
            p_ri = k_in__cmd_isReady;  p_xi = k_in__cmd_isReady && k_in__cmd_canReceive;  p_ci = k_in__cmd;
            p_ro = k_out__cmd_isReady; p_xo = k_out__cmd_isReady && k_out__cmd_canReceive; p_co = k_out__cmd;
            if (p_xk) begin obs_k.push_back(k__cmd);       g_last_k = k;   end
            if (p_xi) begin obs_in.push_back(k_in__cmd);   g_last_in = k;  end
            if (p_xo) begin obs_out.push_back(k_out__cmd); g_last_out = k; end
            if (legal && g_done_cyc != 0) break;
            if (!legal && k >= 4) break;
        end
        if (!legal) begin
            check({nm, " err_cycle"}, 64'(g_err_cyc), 64'd1);
            check({nm, " no_isReady"}, 64'(any_rdy), 64'd0);
            check({nm, " no_done"}, 64'(done_cnt), 64'd0);
            check({nm, " still_idle"}, 64'(job_canReceive), 64'd1);
        end else begin
            if (g_done_cyc == 0) check({nm, " done_timeout"}, 64'd0, 64'd1);
            check({nm, " no_err"}, 64'(g_err_cyc), 64'd0);
            check({nm, " k_count"}, 64'(obs_k.size()), 64'(exp_k.size()));
            check({nm, " in_count"}, 64'(obs_in.size()), 64'(exp_in.size()));
            check({nm, " out_count"}, 64'(obs_out.size()), 64'(exp_out.size()));
            for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++)
                check($sformatf("%s k[%0d]", nm, i), 64'(obs_k[i]), 64'(exp_k[i]));
            for (int i = 0; i < obs_in.size() && i < exp_in.size(); i++)
                check($sformatf("%s in[%0d]", nm, i), 64'(obs_in[i]), 64'(exp_in[i]));
            for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++)
                check($sformatf("%s out[%0d]", nm, i), 64'(obs_out[i]), 64'(exp_out[i]));
            check({nm, " done_after_last"}, 64'(g_done_cyc),
                  64'((g_last_k > g_last_in ? (g_last_k > g_last_out ? g_last_k : g_last_out)
                                            : (g_last_in > g_last_out ? g_last_in : g_last_out)) + 1));
            check({nm, " idle_at_done"}, 64'(can_at_done), 64'd1);
            check({nm, " stable"}, 64'(stable_bad), 64'd0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        job_t j;
        vecs[0] = '{'{1, 1, 8'h96, 8'd3, 1, 9'd5, 4'd2, 1}, 0, 3, 2, 4};
        vecs[1] = '{'{0, 0, 8'h00, 8'd0, 1, 9'd7, 4'd1, 0}, 0, 1, 1, 2};
        vecs[2] = '{'{0, 1, 8'h1F, 8'd0, 0, 9'd511, 4'd15, 1}, 0, 1, 15, 16};
        vecs[3] = '{'{1, 0, 8'h00, 8'hFF, 0, 9'd1, 4'd3, 0}, 0, 1, 3, 4};
        vecs[4] = '{'{1, 1, 8'h5A, 8'd0, 1, 9'd2, 4'd1, 1}, 0, 2, 1, 3};
        vecs[5] = '{'{1, 0, 8'hAA, 8'd0, 0, 9'd3, 4'd2, 1}, 1, 0, 0, 0};
        vecs[6] = '{'{0, 1, 8'h11, 8'd4, 1, 9'd3, 4'd0, 1}, 1, 0, 0, 0};
        vecs[7] = '{'{0, 1, 8'hC3, 8'd9, 0, 9'd64, 4'd4, 0}, 0, 2, 4, 5};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst canReceive", 64'(job_canReceive), 64'd1);
        check("rst isReady", 64'({k__cmd_isReady, k_in__cmd_isReady, k_out__cmd_isReady}), 64'd0);
        check("rst done_err", 64'({job_done, job_err}), 64'd0);

        // Vector table, all sinks ready; jobs are issued back to back.
        for (int v = 0; v < 8; v++) begin
            run_job($sformatf("vec%0d", v), vecs[v].job, 0);
            check($sformatf("vec%0d err", v), 64'(g_err_cyc != 0), 64'(vecs[v].exp_err));
            if (!vecs[v].exp_err) begin
                check($sformatf("vec%0d nin", v), 64'(obs_in.size()), 64'(vecs[v].exp_nin));
                check($sformatf("vec%0d nout", v), 64'(obs_out.size()), 64'(vecs[v].exp_nout));
                check($sformatf("vec%0d done_cyc", v), 64'(g_done_cyc), 64'(vecs[v].exp_done_cyc));
            end
            if (v == 0) begin
                check("full k__cmd", 64'(obs_k[0]), 64'h200A01);
                check("full in0", 64'(obs_in[0]), 64'h4B4);
                check("full in1", 64'(obs_in[1]), 64'h01D);
                check("full in2", 64'(obs_in[2]), 64'h002);
                check("full out0", 64'(obs_out[0]), 64'h3);
                check("full out1", 64'(obs_out[1]), 64'h1);
            end
        end

        // Absorb backpressure for 10 cycles
        run_job("bp", vecs[0].job, 2);
        check("bp k_cycle", 64'(g_last_k), 64'd1);
        check("bp out_cycle", 64'(g_last_out), 64'd2);
        check("bp done_cycle", 64'(g_done_cyc), 64'd14);

        // Reset with two of three absorb commands issued
        @(negedge clk);
        j = vecs[0].job;
        k__cmd_canReceive = 1'b1; k_in__cmd_canReceive = 1'b1; k_out__cmd_canReceive = 1'b0;
        job_is128else256 = j.is128; job_hasDomain = j.has_dom; job_domainByte = j.dom;
        job_zeros = j.zeros; job_forward = j.fwd; job_numBlocks = j.nblk;
        job_numOutCmds = j.nout; job_sample = j.sample; job_isReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_isReady = 1'b0;
        @(negedge clk);
        check("mid in1 pending", 64'(k_in__cmd), 64'h01D);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst isReady", 64'({k__cmd_isReady, k_in__cmd_isReady, k_out__cmd_isReady}), 64'd0);
        check("mid rst canReceive", 64'(job_canReceive), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst no_done", 64'({job_done, job_err}), 64'd0);
        run_job("after_rst", vecs[4].job, 0);

        // Random jobs with random backpressure
        for (int r = 0; r < 40; r++) begin
            j.is128   = 1'($urandom);
            j.has_dom = 1'($urandom);
            j.dom     = 8'($urandom);
            j.zeros   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            j.fwd     = 1'($urandom);
            j.nblk    = 9'($urandom);
            j.nout    = 4'($urandom);
            j.sample  = 1'($urandom);
            run_job($sformatf("rnd%0d", r), j, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
